sha_job_scheduler: RTL and testbench

//  Time-shares one SHA computational block among NUM_REQ nonce-search lanes. Round-robin

---
 rtl/sha_job_scheduler_pkg.sv | 18 +
 rtl/sha_job_scheduler_rr_arbiter.sv | 35 +++
 rtl/sha_job_scheduler.sv | 130 +++++++++++++
 tb/tb_sha_job_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_job_scheduler_pkg.sv
// Shared types and default widths for the SHA job scheduler.
`default_nettype none

package sha_job_scheduler_pkg;

    localparam int SHA_MSG_W  = 1976;
    localparam int SHA_HASH_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/sha_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
`default_nettype none

module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        logic          found;
        int            pos;
        logic [PW-1:0] idx;
        grant = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-two lane counts correct.
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            idx = PW'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha_job_scheduler.sv
// Time-shares one SHA block among NUM_REQ lanes with round-robin arbitration,
// per-lane cancel, a WAIT watchdog and a responded-job counter.
`default_nettype none

module sha_job_scheduler
    import sha_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = SHA_MSG_W,
    parameter int HASH_W  = SHA_HASH_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*MSG_W-1:0]   req_msg,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         cancel,
    output logic                       sha_begin,
    output logic [MSG_W-1:0]           sha_msg,
    input  logic                       sha_complete,
    input  logic [HASH_W-1:0]          sha_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [HASH_W-1:0]          rsp_hash,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       clear_err,
    output logic [31:0]                jobs_done
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);

    sched_state_t  state;
    logic [PW-1:0] owner;
    logic [PW-1:0] ptr;
    logic          discard;
    logic [WD_W-1:0] watchdog;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_next;
    logic          owner_cancel;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) grant_idx = PW'(k);
        end
    end

    assign req_ready    = (state == IDLE && !rst) ? grant : '0;
    assign ptr_next     = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    // A cancel arriving together with completion still suppresses the response.
    assign owner_cancel = cancel[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            discard     <= 1'b0;
            watchdog    <= '0;
            sha_begin   <= 1'b0;
            sha_msg     <= '0;
            rsp_valid   <= '0;
            rsp_hash    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            jobs_done   <= '0;
        end else begin
            sha_begin <= 1'b0;
            rsp_valid <= '0;
            if (clear_err) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner     <= grant_idx;
                        sha_msg   <= req_msg[grant_idx*MSG_W +: MSG_W];
                        sha_begin <= 1'b1;
                        discard   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (owner_cancel) discard <= 1'b1;
                    if (sha_complete) begin
                        ptr <= ptr_next;
                        if (discard || owner_cancel) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rsp_hash  <= sha_out;
                            rsp_valid <= NUM_REQ'(1) << owner;
                            state     <= RESPOND;
                        end
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= ptr_next;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                RESPOND: begin
                    jobs_done <= jobs_done + 32'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha_job_scheduler.sv
// Directed bench: main instance (long watchdog) plus a TIMEOUT=16 instance on shared inputs.
`default_nettype none

module tb_sha_job_scheduler;

    localparam int N  = 4;
    localparam int MW = 64;
    localparam int HW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*MW-1:0] req_msg;
    logic [N-1:0]    cancel;
    logic            sha_complete;
    logic [HW-1:0]   sha_out;
    logic            clear_err;

    logic [N-1:0]  req_ready,   t_req_ready;
    logic          sha_begin,   t_sha_begin;
    logic [MW-1:0] sha_msg,     t_sha_msg;
    logic [N-1:0]  rsp_valid,   t_rsp_valid;
    logic [HW-1:0] rsp_hash,    t_rsp_hash;
    logic          busy,        t_busy;
    logic          timeout_err, t_timeout_err;
    logic [31:0]   jobs_done,   t_jobs_done;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    sha_job_scheduler #(.NUM_REQ(N), .MSG_W(MW), .HASH_W(HW), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg(req_msg),
        .req_ready(req_ready), .cancel(cancel), .sha_begin(sha_begin), .sha_msg(sha_msg),
        .sha_complete(sha_complete), .sha_out(sha_out), .rsp_valid(rsp_valid),
        .rsp_hash(rsp_hash), .busy(busy), .timeout_err(timeout_err),
        .clear_err(clear_err), .jobs_done(jobs_done)
    );

    sha_job_scheduler #(.NUM_REQ(N), .MSG_W(MW), .HASH_W(HW), .TIMEOUT(16)) u_dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg(req_msg),
        .req_ready(t_req_ready), .cancel(cancel), .sha_begin(t_sha_begin), .sha_msg(t_sha_msg),
        .sha_complete(sha_complete), .sha_out(sha_out), .rsp_valid(t_rsp_valid),
        .rsp_hash(t_rsp_hash), .busy(t_busy), .timeout_err(t_timeout_err),
        .clear_err(clear_err), .jobs_done(t_jobs_done)
    );

    function automatic logic [63:0] lane_msg(input int i);
        logic [63:0] base;
        base = 64'h1111_1111_1111_1111;
        return base * 64'(i + 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1; req_valid = '0; cancel = '0; sha_complete = 1'b0;
        sha_out = '0; clear_err = 1'b0;
        for (int i = 0; i < N; i++) req_msg[i*MW +: MW] = lane_msg(i);
        step(3);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_begin", sha_begin, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_sha_msg", sha_msg, 0);
        check("rst_rsp_hash", rsp_hash, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        step(1);

        // 1: single job on lane 2, completion 40 cycles after begin
        req_valid = 4'b0100;
        #1 check("t1_req_ready", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        check("t1_begin", sha_begin, 1);
        check("t1_sha_msg", sha_msg, lane_msg(2));
        check("t1_busy", busy, 1);
        step(1);
        check("t1_begin_pulse", sha_begin, 0);
        step(39);
        sha_complete = 1'b1; sha_out = 64'hDEAD_BEEF_0123_4567;
        step(1);
        sha_complete = 1'b0;
        check("t1_rsp_valid", rsp_valid, 4'b0100);
        check("t1_rsp_hash", rsp_hash, 64'hDEAD_BEEF_0123_4567);
        step(1);
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_jobs_done", jobs_done, 1);
        check("t1_idle", busy, 0);

        // 2: fairness, all lanes continuously valid after reset (ptr = 0)
        rst = 1'b1; step(1); rst = 1'b0;
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            #1 check($sformatf("t2_grant%0d", j), req_ready, 4'b0001 << (j % 4));
            step(1);
            check($sformatf("t2_msg%0d", j), sha_msg, lane_msg(j % 4));
            step(1);
            sha_complete = 1'b1; sha_out = 64'(j) + 64'h100;
            step(1);
            sha_complete = 1'b0;
            check($sformatf("t2_rsp%0d", j), rsp_valid, 4'b0001 << (j % 4));
            check($sformatf("t2_hash%0d", j), rsp_hash, 64'(j) + 64'h100);
            step(1);
        end
        req_valid = '0;
        check("t2_jobs_done", jobs_done, 8);

        // 3: cancel of lane 1 mid-WAIT, lane 2 also pending
        req_valid = 4'b0110;
        #1 check("t3_grant1", req_ready, 4'b0010);
        step(3);
        cancel = 4'b0010;
        step(1);
        cancel = '0;
        step(2);
        sha_complete = 1'b1; sha_out = 64'h5555;
        step(1);
        sha_complete = 1'b0;
        check("t3_no_rsp", rsp_valid, 0);
        check("t3_idle", busy, 0);
        #1 check("t3_grant2", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        check("t3_msg2", sha_msg, lane_msg(2));
        step(1);
        sha_complete = 1'b1; sha_out = 64'h7777;
        step(1);
        sha_complete = 1'b0;
        check("t3_rsp2", rsp_valid, 4'b0100);
        check("t3_hash2", rsp_hash, 64'h7777);
        step(1);
        check("t3_jobs_done", jobs_done, 9);

        // 4: watchdog abort on the TIMEOUT=16 instance
        rst = 1'b1; step(1); rst = 1'b0;
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        check("t4_begin", t_sha_begin, 1);
        step(16);
        check("t4_wait16_err", t_timeout_err, 0);
        check("t4_wait16_busy", t_busy, 1);
        step(1);
        check("t4_err_set", t_timeout_err, 1);
        check("t4_idle", t_busy, 0);
        check("t4_no_rsp", t_rsp_valid, 0);
        check("t4_jobs_done", t_jobs_done, 0);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("t4_err_clear", t_timeout_err, 0);
        sha_complete = 1'b1; sha_out = 64'h9999;
        step(1);
        sha_complete = 1'b0;
        check("t4_stray_rsp", t_rsp_valid, 0);
        check("t4_stray_busy", t_busy, 0);
        step(1);
        check("t4_stray_jobs", t_jobs_done, 0);

        // 5: completion on the watchdog terminal cycle (ptr now 1)
        req_valid = 4'b0010;
        #1 check("t5_grant1", t_req_ready, 4'b0010);
        step(1);
        req_valid = '0;
        step(16);
        sha_complete = 1'b1; sha_out = 64'hABCD;
        step(1);
        sha_complete = 1'b0;
        check("t5_rsp", t_rsp_valid, 4'b0010);
        check("t5_hash", t_rsp_hash, 64'hABCD);
        check("t5_no_err", t_timeout_err, 0);
        step(1);
        check("t5_jobs_done", t_jobs_done, 1);

        // 6: reset while WAIT, then job counter wrap
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(1);
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_begin", sha_begin, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_err", timeout_err, 0);
        check("t6_jobs", jobs_done, 0);
        check("t6_sha_msg", sha_msg, 0);
        check("t6_rsp_hash", rsp_hash, 0);
        force u_dut.jobs_done = 32'hFFFF_FFFF;
        step(1);
        release u_dut.jobs_done;
        #1 check("t6_preset", jobs_done, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(1);
        sha_complete = 1'b1; sha_out = 64'h1234;
        step(1);
        sha_complete = 1'b0;
        check("t6_rsp", rsp_valid, 4'b0001);
        step(1);
        check("t6_wrap", jobs_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
